// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common host commands,
// and the odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Odd parity: the parity bit makes the total count of ones in the
  // nine bits {par, data} odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce filter. A new level is only
// accepted after FILTER_LEN consecutive equal synchronized samples; a
// one-cycle fall pulse marks an accepted 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize, then count consecutive samples that disagree with the
  // accepted level; flip the level once the run is long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= line_in;
      sync <= meta;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Holds the clock low for request-to-send,
// then presents start, eight data bits (LSB first), odd parity and stop on
// the device's falling clock edges, and finally checks the device ack bit.
// All outputs are registered open-drain enables or status pulses.
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  import ps2_pkg::*;

  localparam int RTS_W = $clog2(RTS_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t        state;
  logic [8:0]       sr;
  logic [3:0]       bit_cnt;
  logic [RTS_W-1:0] rts_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             c_fall;
  logic             d_meta;
  logic             d_sync;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2c_in),
    .fall    (c_fall)
  );

  // ps2d only needs synchronizing: it is sampled once, well after it settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      d_meta <= ps2d_in;
      d_sync <= d_meta;
    end
  end

  // Transmit FSM with registered line enables and status pulses; the
  // watchdog covers every state in which the device is expected to clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_ps2) begin
            sr      <= {odd_parity(din), din};
            rts_cnt <= RTS_W'(RTS_CYCLES - 1);
            state   <= RTS;
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
          end
        end
        RTS: begin
          if (rts_cnt == '0) begin
            state   <= START;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            wd_cnt  <= WD_W'(TIMEOUT_CYCLES - 1);
          end else begin
            rts_cnt <= rts_cnt - 1'b1;
          end
        end
        START, DATA, STOP: begin
          if (wd_cnt == '0) begin
            state   <= IDLE;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_idle <= 1'b1;
            tx_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
            if (c_fall) begin
              case (state)
                START: begin
                  state   <= DATA;
                  bit_cnt <= 4'd8;
                  ps2d_oe <= ~sr[0];
                end
                DATA: begin
                  sr <= {1'b0, sr[8:1]};
                  if (bit_cnt == 4'd0) begin
                    state   <= STOP;
                    ps2d_oe <= 1'b0;
                  end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                    ps2d_oe <= ~sr[1];
                  end
                end
                STOP: state <= ACK;
                default: state <= IDLE;
              endcase
            end
          end
        end
        ACK: begin
          state   <= IDLE;
          tx_idle <= 1'b1;
          if (d_sync) tx_err       <= 1'b1;
          else        tx_done_tick <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule
